// File: rtl/operand_sequencer.sv
// -----------------------------------------------------------------------------
// operand_sequencer
//
// Collects an ALU operation from a single bank of data switches.
//   1. Enter loads operand A.
//   2. Enter loads operand B.
//   3. Enter loads the opcode.
//   4. The operation is issued to the ALU as soon as it is ready.
//
// Clear abandons the entry at any point, zeroes all latched values and returns
// to operand A. Enter and Clear are turned into single-cycle events by
// rising-edge detection, so a button held down acts only once.
//
// Optional feature (macro SEQ_TIMEOUT_EN):
//   When defined, a sequence left idle in GET_B or GET_OP for TIMEOUT_CYCLES
//   clocks is cleared automatically. When undefined, there is no counter and
//   every state waits forever.
//
// Parameters:
//   WIDTH           operand width in bits
//   OPCODE_WIDTH    opcode width in bits (must not exceed WIDTH)
//   TIMEOUT_CYCLES  idle-abort interval in clocks (SEQ_TIMEOUT_EN builds only)
//
// Ports:
//   iClock     in   clock; all state updates on its rising edge
//   iResetN    in   asynchronous active-low reset
//   iEnter     in   debounced Enter button, 1 = pressed
//   iClear     in   debounced Clear button, 1 = pressed
//   iSwitches  in   [WIDTH]        data switches, sampled on an Enter event
//   iAluReady  in   ALU can accept a new operation
//   oOperandA  out  [WIDTH]        latched operand A
//   oOperandB  out  [WIDTH]        latched operand B
//   oOpcode    out  [OPCODE_WIDTH] latched opcode
//   oStart     out  one-cycle ALU start strobe (registered)
//   oStage     out  [2]            FSM state register, for the LED display
//
// ALU handshake: iAluReady is the ready and the ISSUE state is the valid. A
// transfer happens on the rising edge where the FSM is in ISSUE and iAluReady
// is 1. oStart is high for exactly the cycle following that edge, and the
// operands and opcode are stable while it is high.
// -----------------------------------------------------------------------------
module operand_sequencer #(
  parameter int WIDTH          = 8,
  parameter int OPCODE_WIDTH   = 3,
  parameter int TIMEOUT_CYCLES = 50000000
) (
  input  logic                    iClock,
  input  logic                    iResetN,
  input  logic                    iEnter,
  input  logic                    iClear,
  input  logic [WIDTH-1:0]        iSwitches,
  input  logic                    iAluReady,
  output logic [WIDTH-1:0]        oOperandA,
  output logic [WIDTH-1:0]        oOperandB,
  output logic [OPCODE_WIDTH-1:0] oOpcode,
  output logic                    oStart,
  output logic [1:0]              oStage
);

  // Elaboration-time parameter sanity check.
  if (OPCODE_WIDTH > WIDTH || TIMEOUT_CYCLES < 2) begin : g_bad_param
    $error("operand_sequencer: need OPCODE_WIDTH <= WIDTH and TIMEOUT_CYCLES >= 2");
  end

  typedef enum logic [1:0] {
    GET_A  = 2'd0,
    GET_B  = 2'd1,
    GET_OP = 2'd2,
    ISSUE  = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [WIDTH-1:0]        a_q, a_d;
  logic [WIDTH-1:0]        b_q, b_d;
  logic [OPCODE_WIDTH-1:0] op_q, op_d;
  logic                    start_q, start_d;
  logic                    enter_q, clear_q;

  logic enter_ev;
  logic clear_ev;
  logic clear_act;   // Clear event, or timeout when the timeout is built in

  assign enter_ev = iEnter & ~enter_q;
  assign clear_ev = iClear & ~clear_q;

`ifdef SEQ_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             waiting;
  logic             timeout_hit;

  assign waiting     = (state_q == GET_B) || (state_q == GET_OP);
  // A real event on the final count wins over the timeout.
  assign timeout_hit = waiting && !enter_ev && !clear_ev &&
                       (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign clear_act   = clear_ev | timeout_hit;

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (!waiting || enter_ev || clear_ev || (state_d != state_q)) begin
      cnt_d = '0;
    end
  end
`else
  assign clear_act = clear_ev;
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    start_d = 1'b0;
    // Clear overrides both Enter and an ALU issue in the same cycle.
    if (clear_act) begin
      state_d = GET_A;
      a_d     = '0;
      b_d     = '0;
      op_d    = '0;
    end else begin
      case (state_q)
        GET_A: if (enter_ev) begin
          a_d     = iSwitches;
          state_d = GET_B;
        end
        GET_B: if (enter_ev) begin
          b_d     = iSwitches;
          state_d = GET_OP;
        end
        GET_OP: if (enter_ev) begin
          op_d    = iSwitches[OPCODE_WIDTH-1:0];
          state_d = ISSUE;
        end
        ISSUE: if (iAluReady) begin
          start_d = 1'b1;
          state_d = GET_A;
        end
        default: state_d = GET_A;
      endcase
    end
  end

  always_ff @(posedge iClock or negedge iResetN) begin
    if (!iResetN) begin
      state_q <= GET_A;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      start_q <= 1'b0;
      enter_q <= 1'b0;
      clear_q <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      start_q <= start_d;
      enter_q <= iEnter;
      clear_q <= iClear;
`ifdef SEQ_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign oOperandA = a_q;
  assign oOperandB = b_q;
  assign oOpcode   = op_q;
  assign oStart    = start_q;
  assign oStage    = state_q;

endmodule

// File: tb/tb_operand_sequencer.sv
// -----------------------------------------------------------------------------
// tb_operand_sequencer
//
// Directed bench for operand_sequencer. Inputs are driven and outputs sampled
// on the falling clock edge. Issued operations are predicted in exp_q as
// {opcode, B, A} and compared when oStart is seen.
// -----------------------------------------------------------------------------
module tb_operand_sequencer;

  localparam int WIDTH = 8;
  localparam int OPW   = 3;
  localparam int SBW   = OPW + 2 * WIDTH;

  logic             clk;
  logic             rst_n;
  logic             enter;
  logic             clear;
  logic [WIDTH-1:0] sw;
  logic             ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [OPW-1:0]   opcode;
  logic             start;
  logic [1:0]       stage;

  int checks = 0;
  int errors = 0;

  logic [SBW-1:0] exp_q[$];
  logic [SBW-1:0] exp_item;

  operand_sequencer #(
    .WIDTH         (WIDTH),
    .OPCODE_WIDTH  (OPW),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .iClock   (clk),
    .iResetN  (rst_n),
    .iEnter   (enter),
    .iClear   (clear),
    .iSwitches(sw),
    .iAluReady(ready),
    .oOperandA(op_a),
    .oOperandB(op_b),
    .oOpcode  (opcode),
    .oStart   (start),
    .oStage   (stage)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic press(input logic [WIDTH-1:0] v);
    sw    = v;
    enter = 1'b1;
    tick();
    enter = 1'b0;
    tick();
  endtask

  // Scenarios
  task automatic test_reset();
    rst_n = 1'b0;
    enter = 1'b0;
    clear = 1'b0;
    ready = 1'b0;
    sw    = '0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (stage !== 2'd0) begin errors++; $display("FAIL reset_stage: got %0d expected 0", stage); end
    checks++;
    if (op_a !== 8'h00 || op_b !== 8'h00 || opcode !== 3'd0) begin
      errors++; $display("FAIL reset_regs: got A=%h B=%h op=%h expected 0", op_a, op_b, opcode);
    end
    checks++;
    if (start !== 1'b0) begin errors++; $display("FAIL reset_start: got %b expected 0", start); end
  endtask

  task automatic test_basic();
    sw    = 8'h2A;
    enter = 1'b1;
    tick();
    checks++;
    if (stage !== 2'd1 || op_a !== 8'h2A) begin
      errors++; $display("FAIL basic_load_a: got stage=%0d A=%h expected 1 2a", stage, op_a);
    end
    enter = 1'b0;
    tick();
    press(8'h15);
    checks++;
    if (stage !== 2'd2 || op_b !== 8'h15) begin
      errors++; $display("FAIL basic_load_b: got stage=%0d B=%h expected 2 15", stage, op_b);
    end
    press(8'h03);
    exp_q.push_back({3'd3, 8'h15, 8'h2A});
    checks++;
    if (stage !== 2'd3 || opcode !== 3'd3 || start !== 1'b0) begin
      errors++; $display("FAIL basic_issue_state: got stage=%0d op=%0d start=%b expected 3 3 0", stage, opcode, start);
    end
    ready = 1'b1;
    tick();
    ready = 1'b0;
    checks++;
    if (start !== 1'b1 || stage !== 2'd0) begin
      errors++; $display("FAIL basic_start: got start=%b stage=%0d expected 1 0", start, stage);
    end else begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++; $display("FAIL basic_sb: got unexpected start expected none");
      end else begin
        exp_item = exp_q.pop_front();
        if ({opcode, op_b, op_a} !== exp_item) begin
          errors++; $display("FAIL basic_sb: got %h expected %h", {opcode, op_b, op_a}, exp_item);
        end
      end
    end
    tick();
    checks++;
    if (start !== 1'b0 || stage !== 2'd0) begin
      errors++; $display("FAIL basic_pulse_width: got start=%b stage=%0d expected 0 0", start, stage);
    end
  endtask

  task automatic test_enter_held();
    sw    = 8'h11;
    enter = 1'b1;
    tick();
    sw = 8'h77;
    for (int i = 0; i < 9; i++) tick();
    checks++;
    if (stage !== 2'd1 || op_a !== 8'h11) begin
      errors++; $display("FAIL held_single_load: got stage=%0d A=%h expected 1 11", stage, op_a);
    end
    enter = 1'b0;
    tick();
    checks++;
    if (stage !== 2'd1) begin errors++; $display("FAIL held_release: got stage=%0d expected 1", stage); end
  endtask

  task automatic test_ready_wait();
    int starts;
    starts = 0;
    press(8'h22);
    press(8'h05);
    exp_q.push_back({3'd5, 8'h22, 8'h11});
    ready = 1'b0;
    sw    = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      enter = (i % 2 == 0);
      tick();
      if (start !== 1'b0 || stage !== 2'd3) starts++;
    end
    enter = 1'b0;
    checks++;
    if (starts != 0) begin errors++; $display("FAIL wait_no_start: got %0d bad cycles expected 0", starts); end
    checks++;
    if (op_a !== 8'h11 || op_b !== 8'h22 || opcode !== 3'd5) begin
      errors++; $display("FAIL wait_enter_ignored: got A=%h B=%h op=%0d expected 11 22 5", op_a, op_b, opcode);
    end
    ready = 1'b1;
    tick();
    ready = 1'b0;
    checks++;
    if (start !== 1'b1) begin
      errors++; $display("FAIL wait_start: got %b expected 1", start);
    end else if (exp_q.size() == 0) begin
      errors++; $display("FAIL wait_sb: got unexpected start expected none");
    end else begin
      exp_item = exp_q.pop_front();
      if ({opcode, op_b, op_a} !== exp_item) begin
        errors++; $display("FAIL wait_sb: got %h expected %h", {opcode, op_b, op_a}, exp_item);
      end
    end
    tick();
    checks++;
    if (start !== 1'b0 || stage !== 2'd0) begin
      errors++; $display("FAIL wait_single_pulse: got start=%b stage=%0d expected 0 0", start, stage);
    end
  endtask

  task automatic test_clear_enter();
    press(8'h44);
    sw    = 8'h99;
    enter = 1'b1;
    clear = 1'b1;
    tick();
    checks++;
    if (op_a !== 8'h00 || op_b !== 8'h00 || opcode !== 3'd0 || stage !== 2'd0) begin
      errors++; $display("FAIL clear_over_enter: got A=%h B=%h op=%0d stage=%0d expected 0 0 0 0", op_a, op_b, opcode, stage);
    end
    enter = 1'b0;
    clear = 1'b0;
    tick();
    checks++;
    if (stage !== 2'd0 || op_a !== 8'h00) begin
      errors++; $display("FAIL clear_release: got stage=%0d A=%h expected 0 00", stage, op_a);
    end
    press(8'h01);
    press(8'h02);
    press(8'h03);
    ready = 1'b1;
    clear = 1'b1;
    tick();
    ready = 1'b0;
    clear = 1'b0;
    checks++;
    if (start !== 1'b0 || stage !== 2'd0 || op_a !== 8'h00) begin
      errors++; $display("FAIL clear_over_issue: got start=%b stage=%0d A=%h expected 0 0 00", start, stage, op_a);
    end
    tick();
  endtask

  task automatic test_async_reset();
    press(8'h31);
    press(8'h32);
    checks++;
    if (stage !== 2'd2) begin errors++; $display("FAIL arst_setup: got stage=%0d expected 2", stage); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (stage !== 2'd0 || op_a !== 8'h00 || op_b !== 8'h00 || start !== 1'b0) begin
      errors++; $display("FAIL arst_immediate: got stage=%0d A=%h B=%h start=%b expected 0 00 00 0", stage, op_a, op_b, start);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++;
    if (stage !== 2'd0 || op_a !== 8'h00) begin
      errors++; $display("FAIL arst_no_event: got stage=%0d A=%h expected 0 00", stage, op_a);
    end
    press(8'h0A);
    checks++;
    if (stage !== 2'd1 || op_a !== 8'h0A) begin
      errors++; $display("FAIL arst_resume: got stage=%0d A=%h expected 1 0a", stage, op_a);
    end
  endtask

`ifdef SEQ_TIMEOUT_EN
  task automatic test_timeout();
    // In GET_B since the first edge of the press above; one idle edge done.
    for (int i = 0; i < 14; i++) tick();
    checks++;
    if (stage !== 2'd1) begin errors++; $display("FAIL timeout_early: got stage=%0d expected 1", stage); end
    tick();
    checks++;
    if (stage !== 2'd0 || op_a !== 8'h00) begin
      errors++; $display("FAIL timeout_fire: got stage=%0d A=%h expected 0 00", stage, op_a);
    end
    press(8'h0B);
    for (int i = 0; i < 13; i++) tick();
    sw    = 8'h0C;
    enter = 1'b1;
    tick();
    enter = 1'b0;
    checks++;
    if (stage !== 2'd2 || op_a !== 8'h0B || op_b !== 8'h0C) begin
      errors++; $display("FAIL timeout_prevented: got stage=%0d A=%h B=%h expected 2 0b 0c", stage, op_a, op_b);
    end
    tick();
    checks++;
    if (stage !== 2'd2) begin errors++; $display("FAIL timeout_reset_count: got stage=%0d expected 2", stage); end
  endtask
`else
  task automatic test_timeout();
    for (int i = 0; i < 40; i++) tick();
    checks++;
    if (stage !== 2'd1 || op_a !== 8'h0A) begin
      errors++; $display("FAIL no_timeout_wait: got stage=%0d A=%h expected 1 0a", stage, op_a);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_enter_held();
    test_ready_wait();
    test_clear_enter();
    test_async_reset();
    test_timeout();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL sb_leftover: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/operand_sequencer.md
OPERAND_SEQUENCER -- requirements
Module: operand_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand width in bits.
REQ-002 SHALL have parameter OPCODE_WIDTH, default 3, meaning opcode width in bits; OPCODE_WIDTH <= WIDTH.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 50000000, meaning the idle-abort interval in clocks; used only when SEQ_TIMEOUT_EN is defined.
REQ-004 SHALL have port iClock  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port iResetN  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port iEnter  input  1  debounced Enter button; 1 = pressed.
REQ-007 SHALL have port iClear  input  1  debounced Clear button; 1 = pressed.
REQ-008 SHALL have port iSwitches  input  WIDTH  data switches, sampled on Enter.
REQ-009 SHALL have port iAluReady  input  1  ALU can accept a new operation.
REQ-010 SHALL have port oOperandA  output  WIDTH  latched operand A.
REQ-011 SHALL have port oOperandB  output  WIDTH  latched operand B.
REQ-012 SHALL have port oOpcode  output  OPCODE_WIDTH  latched opcode.
REQ-013 SHALL have port oStart  output  1  one-cycle ALU start strobe.
REQ-014 SHALL have port oStage  output  2  current state encoding, for LED display.

Function
REQ-015 SHALL implement a 4-state FSM: GET_A=0, GET_B=1, GET_OP=2, ISSUE=3; oStage equals the state register.
REQ-016 SHALL derive Enter and Clear events by registered rising-edge detection: event = input high AND previous-cycle copy low; a level held high yields exactly one event.
REQ-017 SHALL, on an Enter event in GET_A, load oOperandA <= iSwitches and go to GET_B at the same edge.
REQ-018 SHALL, on an Enter event in GET_B, load oOperandB <= iSwitches and go to GET_OP.
REQ-019 SHALL, on an Enter event in GET_OP, load oOpcode <= iSwitches[OPCODE_WIDTH-1:0] and go to ISSUE.
REQ-020 SHALL ignore Enter events in ISSUE.
REQ-021 SHALL, in ISSUE with iAluReady=1, drive oStart=1 for exactly one cycle (registered) and enter GET_A at the same edge; with iAluReady=0, hold ISSUE and keep oStart=0.
REQ-022 SHALL hold oOperandA, oOperandB and oOpcode stable except on their load edge or on a Clear event.
REQ-023 SHALL, on a Clear event in any state, zero oOperandA, oOperandB and oOpcode, force GET_A and suppress oStart for that cycle.
REQ-024 SHALL give Clear priority over Enter and over ALU issue when both occur in the same cycle.
REQ-025 SHALL have one-edge latency: an event sampled at edge N is reflected in outputs after edge N.

Reset
REQ-026 SHALL, while iResetN=0, asynchronously force state GET_A, oOperandA=0, oOperandB=0, oOpcode=0, oStart=0, edge-detect registers=0 and timeout counter=0.
REQ-027 SHALL abandon any partial entry on reset mid-sequence and generate no Enter or Clear event on the first edge after release if inputs are low.

Configuration
REQ-028 SHALL, with SEQ_TIMEOUT_EN defined, count clocks spent in GET_B or GET_OP with no Enter or Clear event. The counter resets on any event or state change. When it reaches TIMEOUT_CYCLES-1, the block SHALL perform the REQ-023 Clear action on the next edge.
REQ-029 SHALL, without SEQ_TIMEOUT_EN, contain no timeout counter and wait in any state indefinitely.

Verification
REQ-030 SHALL cover: Enter with switches 0x2A, then 0x15, then 0x03, iAluReady=1 -> A=0x2A, B=0x15, opcode=3; oStart high exactly one cycle, oStage back to 0.
REQ-031 SHALL cover: iEnter held high 10 cycles in GET_A -> exactly one load; oStage=1, not 2.
REQ-032 SHALL cover: reach ISSUE with iAluReady=0 for 5 cycles, then 1 -> oStart=0 for those 5 cycles, then a single pulse; extra Enter events in ISSUE are ignored.
REQ-033 SHALL cover: Clear and Enter rising in the same cycle in GET_B -> A=B=opcode=0, oStage=0.
REQ-034 SHALL cover: iResetN pulsed low in GET_OP, asynchronously between clock edges -> outputs zero immediately, before the next clock edge.
REQ-035 SHALL cover, with SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=16: idle in GET_B -> return to GET_A with operands cleared after 16 cycles; an Enter at cycle 15 prevents the timeout.
